// File: rtl/wisc_pkg.sv
// Shared WISC-S18 fetch-stage definitions: opcodes, condition codes, FSM states, flag bit positions.
// Latency: n/a (constants, types and pure helper functions only).
// Backpressure: n/a.
package wisc_pkg;

    // Opcodes live in instr[15:12].
    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_NAND   = 4'h2;
    localparam logic [3:0] OP_XOR    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    // Branch condition codes live in instr[11:9].
    localparam logic [2:0] CC_NE     = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_GT     = 3'b010;
    localparam logic [2:0] CC_LT     = 3'b011;
    localparam logic [2:0] CC_GTE    = 3'b100;
    localparam logic [2:0] CC_LTE    = 3'b101;
    localparam logic [2:0] CC_OVFL   = 3'b110;
    localparam logic [2:0] CC_UNCOND = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fsm_state_t;

    // Flag register is packed {Z,V,N}.
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Byte offset of a B instruction: sign-extended 9-bit word offset, times two.
    function automatic logic [15:0] branchOffset(input logic [8:0] imm9);
        return {{6{imm9[8]}}, imm9, 1'b0};
    endfunction

    // Arithmetic ops that write all three flags.
    function automatic logic setsAllFlags(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Logic/shift ops that write only Z.
    function automatic logic setsZeroOnly(input logic [3:0] op);
        return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: instruction memory side, ALU flag inputs, PC/halt/status outputs.
// Latency: n/a (wires only).
// Backpressure: a single stall level; no valid/ready pairing on this bus.
// Ports: master = fetch unit (drives imem_addr/imem_en/instruction/pc/pc_plus2/hlt/flags/inst_count),
//        slave  = surrounding core / memory (drives imem_data/stall/alu_*/reg_target).
interface pc_fetch_unit_if #(
    parameter int CNT_W = 16
);
    logic [15:0]      imem_data;
    logic             stall;
    logic             alu_z;
    logic             alu_v;
    logic             alu_n;
    logic [15:0]      reg_target;
    logic [15:0]      imem_addr;
    logic             imem_en;
    logic [15:0]      instruction;
    logic [15:0]      pc;
    logic [15:0]      pc_plus2;
    logic             hlt;
    logic [2:0]       flags;
    logic [CNT_W-1:0] inst_count;

    modport master (
        input  imem_data, stall, alu_z, alu_v, alu_n, reg_target,
        output imem_addr, imem_en, instruction, pc, pc_plus2, hlt, flags, inst_count
    );

    modport slave (
        output imem_data, stall, alu_z, alu_v, alu_n, reg_target,
        input  imem_addr, imem_en, instruction, pc, pc_plus2, hlt, flags, inst_count
    );
endinterface

// File: rtl/pc_fetch_unit_branch_cond_eval.sv
// Evaluates a 3-bit branch condition code against the registered {Z,V,N} flags.
// Latency: purely combinational.
// Backpressure: none.
// Ports: ccc (condition code), flags ({Z,V,N}), taken (1 = branch condition holds).
module branch_cond_eval
    import wisc_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       taken
);
    logic z;
    logic v;
    logic n;

    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        unique case (ccc)
            CC_NE:     taken = !z;
            CC_EQ:     taken = z;
            CC_GT:     taken = !z && !n;
            CC_LT:     taken = n;
            CC_GTE:    taken = z || (!z && !n);
            CC_LTE:    taken = z || n;
            CC_OVFL:   taken = v;
            CC_UNCOND: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch/PC-control stage: holds PC, {Z,V,N} flags, retired count and the idle/run/halt FSM; resolves B/BR/PCS next-PC.
// Latency: single cycle; fetch address and hlt are combinational from current state, PC/flags update on the next posedge.
// Backpressure: stall=1 freezes PC, flags, counter and FSM for that cycle.
// Ports: clk, rst_n (sync, active-low), bus (pc_fetch_unit_if.master: imem_data/stall/alu_*/reg_target in,
//        imem_addr/imem_en/instruction/pc/pc_plus2/hlt/flags/inst_count out).
module pc_fetch_unit
    import wisc_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_fetch_unit_if.master  bus
);
    fsm_state_t       state;
    fsm_state_t       stateNext;
    logic [15:0]      pcQ;
    logic [15:0]      pcNext;
    logic [15:0]      pcPlus2;
    logic [2:0]       flagsQ;
    logic [2:0]       flagsNext;
    logic [CNT_W-1:0] cntQ;

    logic [3:0]       opcode;
    logic             isHaltOp;
    logic             retire;
    logic             taken;
    logic             imemEn;
    logic             hltOut;
    logic [15:0]      instOut;

    assign opcode   = bus.imem_data[15:12];
    assign isHaltOp = (opcode == HALT_OPCODE);
    // An instruction retires on a running, unstalled cycle; the halt instruction itself counts.
    assign retire   = (state == S_RUN) && !bus.stall;
    assign pcPlus2  = pcQ + 16'd2;

    // Branches test the flags written on earlier edges, never this cycle's ALU outputs.
    branch_cond_eval uCondEval (
        .ccc   (bus.imem_data[11:9]),
        .flags (flagsQ),
        .taken (taken)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        stateNext = state;
        unique case (state)
            S_IDLE:  stateNext = S_RUN;
            S_RUN:   if (isHaltOp && !bus.stall) stateNext = S_HALT;
            S_HALT:  stateNext = S_HALT;
            default: stateNext = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Gated by rst_n so the outputs read as idle for the whole reset cycle, whatever state preceded it.
    always_comb begin
        imemEn  = 1'b0;
        hltOut  = 1'b0;
        instOut = 16'h0000;
        if (rst_n) begin
            unique case (state)
                S_RUN: begin
                    imemEn  = 1'b1;
                    hltOut  = isHaltOp;
                    instOut = bus.imem_data;
                end
                S_HALT: begin
                    imemEn = 1'b1;
                    hltOut = 1'b1;
                end
                default: begin
                    imemEn  = 1'b0;
                    hltOut  = 1'b0;
                    instOut = 16'h0000;
                end
            endcase
        end
    end

    // ---------------- next PC ----------------
    always_comb begin
        pcNext = pcQ;
        if (retire && !isHaltOp) begin
            unique case (opcode)
                OP_B:    pcNext = taken ? (pcPlus2 + branchOffset(bus.imem_data[8:0])) : pcPlus2;
                OP_BR:   pcNext = taken ? bus.reg_target : pcPlus2;
                default: pcNext = pcPlus2;
            endcase
        end
    end

    // ---------------- next flags ----------------
    always_comb begin
        flagsNext = flagsQ;
        if (retire) begin
            if (setsAllFlags(opcode)) begin
                flagsNext[FLAG_Z] = bus.alu_z;
                flagsNext[FLAG_V] = bus.alu_v;
                flagsNext[FLAG_N] = bus.alu_n;
            end else if (setsZeroOnly(opcode)) begin
                flagsNext[FLAG_Z] = bus.alu_z;
            end
        end
    end

    // ---------------- architectural registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcQ    <= RESET_PC;
            flagsQ <= 3'b000;
            cntQ   <= '0;
        end else begin
            pcQ    <= pcNext;
            flagsQ <= flagsNext;
            if (retire) begin
                cntQ <= cntQ + CNT_W'(1);
            end
        end
    end

    assign bus.imem_addr   = pcQ;
    assign bus.pc          = pcQ;
    assign bus.pc_plus2    = pcPlus2;
    assign bus.imem_en     = imemEn;
    assign bus.hlt         = hltOut;
    assign bus.instruction = instOut;
    assign bus.flags       = flagsQ;
    assign bus.inst_count  = cntQ;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: vector tables applied in a loop, post-edge state checked through a scoreboard queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_pc_fetch_unit;

    typedef struct {
        logic [15:0] instr;
        logic        stall;
        logic [2:0]  alu;      // {z,v,n}
        logic [15:0] tgt;
        logic        expHlt;
        logic [15:0] expInst;
        logic [15:0] expPc;
        logic [2:0]  expFlags;
        logic [15:0] expCnt;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [2:0]  flags;
        logic [15:0] cnt;
        int          idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] curPc;
    exp_t sb[$];
    vec_t progA[$];
    vec_t progB[$];

    always #5 clk = ~clk;

    pc_fetch_unit_if #(.CNT_W(16)) bus ();

    pc_fetch_unit #(
        .RESET_PC    (16'h0000),
        .HALT_OPCODE (4'hF),
        .CNT_W       (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic vec_t mk(input logic [15:0] instr, input logic stall, input logic [2:0] alu,
                                input logic [15:0] tgt, input logic expHlt, input logic [15:0] expInst,
                                input logic [15:0] expPc, input logic [2:0] expFlags, input logic [15:0] expCnt);
        vec_t t;
        t.instr = instr; t.stall = stall; t.alu = alu; t.tgt = tgt;
        t.expHlt = expHlt; t.expInst = expInst; t.expPc = expPc;
        t.expFlags = expFlags; t.expCnt = expCnt;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] instr, input logic stall, input logic [2:0] alu, input logic [15:0] tgt);
        bus.imem_data  = instr;
        bus.stall      = stall;
        bus.alu_z      = alu[2];
        bus.alu_v      = alu[1];
        bus.alu_n      = alu[0];
        bus.reg_target = tgt;
    endtask

    task automatic applyVec(input vec_t t, input string tag, input int idx);
        exp_t e;
        logic [15:0] p2;
        @(negedge clk);
        drive(t.instr, t.stall, t.alu, t.tgt);
        #1;
        p2 = curPc + 16'd2;
        check($sformatf("%s[%0d] hlt", tag, idx), {31'd0, bus.hlt}, {31'd0, t.expHlt});
        check($sformatf("%s[%0d] instruction", tag, idx), {16'd0, bus.instruction}, {16'd0, t.expInst});
        check($sformatf("%s[%0d] imem_addr", tag, idx), {16'd0, bus.imem_addr}, {16'd0, curPc});
        check($sformatf("%s[%0d] pc_plus2", tag, idx), {16'd0, bus.pc_plus2}, {16'd0, p2});
        check($sformatf("%s[%0d] imem_en", tag, idx), {31'd0, bus.imem_en}, 32'd1);
        e.pc = t.expPc; e.flags = t.expFlags; e.cnt = t.expCnt; e.idx = idx;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s[%0d] scoreboard: got empty queue expected one entry", tag, idx);
        end else begin
            e = sb.pop_front();
            check($sformatf("%s[%0d] pc", tag, e.idx), {16'd0, bus.pc}, {16'd0, e.pc});
            check($sformatf("%s[%0d] flags", tag, e.idx), {29'd0, bus.flags}, {29'd0, e.flags});
            check($sformatf("%s[%0d] inst_count", tag, e.idx), {16'd0, bus.inst_count}, {16'd0, e.cnt});
            curPc = e.pc;
        end
    endtask

    // Hold reset for nEdges posedges with a live-looking ADD on the bus, then release and
    // confirm the idle cycle executes nothing before the core enters run.
    task automatic doReset(input int nEdges, input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        drive(16'h0123, 1'b0, 3'b111, 16'hAAAA);
        #1;
        check({tag, " hlt during reset"}, {31'd0, bus.hlt}, 32'd0);
        check({tag, " instruction during reset"}, {16'd0, bus.instruction}, 32'd0);
        repeat (nEdges) @(posedge clk);
        #1;
        check({tag, " pc after reset"}, {16'd0, bus.pc}, 32'h0000);
        check({tag, " flags after reset"}, {29'd0, bus.flags}, 32'd0);
        check({tag, " inst_count after reset"}, {16'd0, bus.inst_count}, 32'd0);
        check({tag, " hlt after reset"}, {31'd0, bus.hlt}, 32'd0);
        check({tag, " imem_en after reset"}, {31'd0, bus.imem_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check({tag, " idle instruction"}, {16'd0, bus.instruction}, 32'd0);
        check({tag, " idle imem_en"}, {31'd0, bus.imem_en}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, " pc after idle"}, {16'd0, bus.pc}, 32'h0000);
        check({tag, " flags after idle"}, {29'd0, bus.flags}, 32'd0);
        check({tag, " inst_count after idle"}, {16'd0, bus.inst_count}, 32'd0);
        check({tag, " imem_en in run"}, {31'd0, bus.imem_en}, 32'd1);
        curPc = 16'h0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Straight-line program: 3x ADD then HLT at 0x0006, then one cycle sitting in halt.
        progA.push_back(mk(16'h0123, 1'b0, 3'b000, 16'h0000, 1'b0, 16'h0123, 16'h0002, 3'b000, 16'd1));
        progA.push_back(mk(16'h0123, 1'b0, 3'b000, 16'h0000, 1'b0, 16'h0123, 16'h0004, 3'b000, 16'd2));
        progA.push_back(mk(16'h0123, 1'b0, 3'b000, 16'h0000, 1'b0, 16'h0123, 16'h0006, 3'b000, 16'd3));
        progA.push_back(mk(16'hF000, 1'b0, 3'b000, 16'h0000, 1'b1, 16'hF000, 16'h0006, 3'b000, 16'd4));
        progA.push_back(mk(16'h0123, 1'b0, 3'b111, 16'h0000, 1'b1, 16'h0000, 16'h0006, 3'b000, 16'd4));

        // Branch, flag, stall and wrap program starting from pc=0, flags=000, count=0.
        progB.push_back(mk(16'hDE00, 1'b0, 3'b000, 16'h000E, 1'b0, 16'hDE00, 16'h000E, 3'b000, 16'd1));  // BR uncond
        progB.push_back(mk(16'h1000, 1'b0, 3'b100, 16'h0000, 1'b0, 16'h1000, 16'h0010, 3'b100, 16'd2));  // SUB z=1
        progB.push_back(mk(16'hC204, 1'b0, 3'b000, 16'h0000, 1'b0, 16'hC204, 16'h001A, 3'b100, 16'd3));  // B EQ taken
        progB.push_back(mk(16'hDE00, 1'b0, 3'b000, 16'h000E, 1'b0, 16'hDE00, 16'h000E, 3'b100, 16'd4));
        progB.push_back(mk(16'h1000, 1'b0, 3'b001, 16'h0000, 1'b0, 16'h1000, 16'h0010, 3'b001, 16'd5));  // SUB z=0 n=1
        progB.push_back(mk(16'hC204, 1'b0, 3'b100, 16'h0000, 1'b0, 16'hC204, 16'h0012, 3'b001, 16'd6));  // B EQ not taken
        progB.push_back(mk(16'hC606, 1'b0, 3'b000, 16'h0000, 1'b0, 16'hC606, 16'h0020, 3'b001, 16'd7));  // B LT taken
        progB.push_back(mk(16'hCFFF, 1'b0, 3'b000, 16'h0000, 1'b0, 16'hCFFF, 16'h0020, 3'b001, 16'd8));  // self-loop
        progB.push_back(mk(16'hDE00, 1'b0, 3'b000, 16'h1234, 1'b0, 16'hDE00, 16'h1234, 3'b001, 16'd9));
        progB.push_back(mk(16'h0123, 1'b0, 3'b000, 16'h0000, 1'b0, 16'h0123, 16'h1236, 3'b000, 16'd10)); // ADD clears
        progB.push_back(mk(16'h3000, 1'b0, 3'b111, 16'h0000, 1'b0, 16'h3000, 16'h1238, 3'b100, 16'd11)); // XOR: Z only
        progB.push_back(mk(16'h0123, 1'b0, 3'b010, 16'h0000, 1'b0, 16'h0123, 16'h123A, 3'b010, 16'd12)); // ADD v=1
        progB.push_back(mk(16'hCC10, 1'b0, 3'b000, 16'h0000, 1'b0, 16'hCC10, 16'h125C, 3'b010, 16'd13)); // B OVFL taken
        progB.push_back(mk(16'hC400, 1'b0, 3'b000, 16'h0000, 1'b0, 16'hC400, 16'h125E, 3'b010, 16'd14)); // B GT taken
        progB.push_back(mk(16'hCA40, 1'b0, 3'b000, 16'h0000, 1'b0, 16'hCA40, 16'h1260, 3'b010, 16'd15)); // B LTE not taken
        progB.push_back(mk(16'hD200, 1'b0, 3'b000, 16'hBEEF, 1'b0, 16'hD200, 16'h1262, 3'b010, 16'd16)); // BR EQ not taken
        progB.push_back(mk(16'hDE00, 1'b0, 3'b000, 16'h0040, 1'b0, 16'hDE00, 16'h0040, 3'b010, 16'd17));
        progB.push_back(mk(16'h0123, 1'b1, 3'b100, 16'h0000, 1'b0, 16'h0123, 16'h0040, 3'b010, 16'd17)); // stall x3
        progB.push_back(mk(16'h0123, 1'b1, 3'b100, 16'h0000, 1'b0, 16'h0123, 16'h0040, 3'b010, 16'd17));
        progB.push_back(mk(16'h0123, 1'b1, 3'b100, 16'h0000, 1'b0, 16'h0123, 16'h0040, 3'b010, 16'd17));
        progB.push_back(mk(16'h0123, 1'b0, 3'b100, 16'h0000, 1'b0, 16'h0123, 16'h0042, 3'b100, 16'd18)); // release
        progB.push_back(mk(16'hF000, 1'b1, 3'b000, 16'h0000, 1'b1, 16'hF000, 16'h0042, 3'b100, 16'd18)); // stalled HLT
        progB.push_back(mk(16'hDE00, 1'b0, 3'b000, 16'hFFFE, 1'b0, 16'hDE00, 16'hFFFE, 3'b100, 16'd19));
        progB.push_back(mk(16'h0123, 1'b0, 3'b000, 16'h0000, 1'b0, 16'h0123, 16'h0000, 3'b000, 16'd20)); // wrap
        progB.push_back(mk(16'hF000, 1'b0, 3'b000, 16'h0000, 1'b1, 16'hF000, 16'h0000, 3'b000, 16'd21)); // HLT
        progB.push_back(mk(16'h0123, 1'b0, 3'b111, 16'h0000, 1'b1, 16'h0000, 16'h0000, 3'b000, 16'd21)); // halted

        rst_n = 1'b0;
        curPc = 16'h0000;
        drive(16'h0000, 1'b0, 3'b000, 16'h0000);

        doReset(2, "por");
        for (int i = 0; i < progA.size(); i++) applyVec(progA[i], "A", i);

        // Reset taken from inside S_HALT must restore everything on that single edge.
        doReset(1, "haltrst");
        for (int i = 0; i < progB.size(); i++) applyVec(progB[i], "B", i);

        check("scoreboard drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
